// File: rtl/sccb_cmd_arbiter_pkg.sv
// Shared types and constants for the two-port SCCB command arbiter.
package sccb_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic [15:0] CMD_END        = 16'hFFFF;
  localparam logic [15:0] CMD_COM7_RESET = 16'h1280;
  localparam logic [7:0]  SCCB_ID_OV7670 = 8'h42;

  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_gap_timer.sv
// Loadable down-counter with zero flag; stops at 0 instead of wrapping.
module sccb_gap_timer #(
  parameter int W = 16,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Two-port arbiter in front of the SCCB command sender with inter-command gaps.
// Optional ISSUE timeout with sticky error is enabled by defining SCCB_TIMEOUT_EN.
module sccb_cmd_arbiter
  import sccb_cmd_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES        = 256,
  parameter int RESET_WAIT_CYCLES = 25000,
  parameter int FIXED_PRIO_A      = 1,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [15:0] a_cmd,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [15:0] b_cmd,
  output logic        b_ack,
  output logic        sccb_send,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_value,
  input  logic        sccb_taken,
  output logic        grant_b,
  output logic        busy,
  output logic        err_timeout
);

  localparam int GAP_EFF = at_least_one(GAP_CYCLES);
  localparam int RW_EFF  = at_least_one(RESET_WAIT_CYCLES);
  localparam int TO_EFF  = at_least_one(TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(max3(GAP_EFF, RW_EFF, TO_EFF)) + 1;

  // Counters are loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] RW_LOAD  = CNT_W'(RW_EFF - 1);

  arb_state_e       state;
  logic             last_grant_b;
  logic             win_b;
  logic [15:0]      win_cmd;
  logic             any_req;
  logic             timeout_hit;
  logic             gap_load;
  logic [CNT_W-1:0] gap_value;
  logic             gap_zero;

  assign any_req = a_req | b_req;
  assign win_b   = b_req & (~a_req | ((FIXED_PRIO_A == 0) & ~last_grant_b));
  assign win_cmd = win_b ? b_cmd : a_cmd;

  always_comb begin
    gap_load  = 1'b0;
    gap_value = '0;
    case (state)
      ST_IDLE: begin
        if (any_req && (win_cmd == CMD_END)) begin
          gap_load = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (sccb_taken) begin
          gap_load  = 1'b1;
          gap_value = ({sccb_reg, sccb_value} == CMD_COM7_RESET) ? RW_LOAD : GAP_LOAD;
        end else if (timeout_hit) begin
          gap_load  = 1'b1;
          gap_value = RW_LOAD;
        end
      end
      default: ;
    endcase
  end

  sccb_gap_timer #(
    .W    (CNT_W),
    .INIT (RW_LOAD)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gap_load),
    .load_value (gap_value),
    .en         (state == ST_GAP),
    .zero       (gap_zero)
  );

`ifdef SCCB_TIMEOUT_EN
  logic to_zero;

  // Held at full count while idle, so ISSUE starts with a fresh budget.
  sccb_gap_timer #(
    .W    (CNT_W),
    .INIT ('0)
  ) u_timeout_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == ST_IDLE),
    .load_value (CNT_W'(TO_EFF - 1)),
    .en         (state == ST_ISSUE),
    .zero       (to_zero)
  );

  assign timeout_hit = (state == ST_ISSUE) & ~sccb_taken & to_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GAP;
      sccb_send    <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      sccb_reg     <= 8'h00;
      sccb_value   <= 8'h00;
      grant_b      <= 1'b0;
      busy         <= 1'b1;
      last_grant_b <= 1'b1;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_b                <= win_b;
            last_grant_b           <= win_b;
            {sccb_reg, sccb_value} <= win_cmd;
            busy                   <= 1'b1;
            // The table end marker is acknowledged without touching the sender.
            if (win_cmd == CMD_END) begin
              state <= ST_GAP;
              a_ack <= ~win_b;
              b_ack <= win_b;
            end else begin
              state     <= ST_ISSUE;
              sccb_send <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (sccb_taken || timeout_hit) begin
            sccb_send <= 1'b0;
            a_ack     <= ~grant_b;
            b_ack     <= grant_b;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sccb_send <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Directed, table-driven bench for sccb_cmd_arbiter (round-robin ties, default gaps).
module tb_sccb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0;
  logic [15:0] a_cmd = 16'h0000;
  logic        a_ack;
  logic        b_req = 1'b0;
  logic [15:0] b_cmd = 16'h0000;
  logic        b_ack;
  logic        sccb_send;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_value;
  logic        sccb_taken = 1'b0;
  logic        grant_b;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sccb_cmd_arbiter #(
    .GAP_CYCLES        (256),
    .RESET_WAIT_CYCLES (25000),
    .FIXED_PRIO_A      (0),
    .TIMEOUT_CYCLES    (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .a_cmd       (a_cmd),
    .a_ack       (a_ack),
    .b_req       (b_req),
    .b_cmd       (b_cmd),
    .b_ack       (b_ack),
    .sccb_send   (sccb_send),
    .sccb_reg    (sccb_reg),
    .sccb_value  (sccb_value),
    .sccb_taken  (sccb_taken),
    .grant_b     (grant_b),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic        a_req;
    logic [15:0] a_cmd;
    logic        b_req;
    logic [15:0] b_cmd;
    int          delay;
    logic        drop;
    logic        exp_b;
    logic [15:0] exp_cmd;
    logic        exp_end;
    int          exp_gap;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts busy cycles from the current (first GAP) cycle until IDLE.
  task automatic measure_gap(input string name, input int exp_gap, input logic check_ack);
    int   n;
    logic saw_send;
    logic ack_after;
    n = 0;
    saw_send = 1'b0;
    ack_after = 1'b0;
    while (busy && n < 30000) begin
      tick();
      n++;
      if (sccb_send) saw_send = 1'b1;
      if (n == 1) ack_after = a_ack | b_ack;
    end
    check({name, " gap_len"}, n, exp_gap);
    check({name, " no_send_in_gap"}, {31'd0, saw_send}, 0);
    if (check_ack) check({name, " ack_one_cycle"}, {31'd0, ack_after}, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    a_req = v.a_req; a_cmd = v.a_cmd;
    b_req = v.b_req; b_cmd = v.b_cmd;
    tick();
    check({nm, " grant_b"}, {31'd0, grant_b}, {31'd0, v.exp_b});
    check({nm, " reg_value"}, {16'd0, sccb_reg, sccb_value}, {16'd0, v.exp_cmd});
    if (v.exp_end) begin
      check({nm, " send_low"}, {31'd0, sccb_send}, 0);
      check({nm, " acks"}, {30'd0, a_ack, b_ack}, v.exp_b ? 32'd1 : 32'd2);
    end else begin
      check({nm, " send_high"}, {31'd0, sccb_send}, 1);
      check({nm, " no_early_ack"}, {30'd0, a_ack, b_ack}, 0);
      if (v.drop) begin
        if (v.exp_b) b_req = 1'b0; else a_req = 1'b0;
      end
      for (int i = 0; i < v.delay; i++) tick();
      check({nm, " send_held"}, {31'd0, sccb_send}, 1);
      sccb_taken = 1'b1;
      tick();
      sccb_taken = 1'b0;
      check({nm, " send_dropped"}, {31'd0, sccb_send}, 0);
      check({nm, " acks"}, {30'd0, a_ack, b_ack}, v.exp_b ? 32'd1 : 32'd2);
    end
    if (v.exp_b) b_req = 1'b0; else a_req = 1'b0;
    measure_gap(nm, v.exp_gap, 1'b1);
    $display("txn %s: grant_b=%0d cmd=%04h end=%0d", nm, v.exp_b, v.exp_cmd, v.exp_end);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          a_req a_cmd     b_req b_cmd     dly drop exp_b exp_cmd   end gap
    vecs[0] = '{1'b1, 16'h3A04, 1'b0, 16'h0000, 3, 1'b0, 1'b0, 16'h3A04, 1'b0, 256};
    vecs[1] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 0, 1'b0, 1'b1, 16'h2222, 1'b0, 256};
    vecs[2] = '{1'b1, 16'h1111, 1'b1, 16'h3344, 1, 1'b0, 1'b0, 16'h1111, 1'b0, 256};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'h3344, 2, 1'b0, 1'b1, 16'h3344, 1'b0, 256};
    vecs[4] = '{1'b1, 16'h1280, 1'b1, 16'h1300, 0, 1'b0, 1'b0, 16'h1280, 1'b0, 25000};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'h1300, 1, 1'b0, 1'b1, 16'h1300, 1'b0, 256};
    vecs[6] = '{1'b1, 16'hFFFF, 1'b1, 16'h7788, 0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 16'h7788, 0, 1'b0, 1'b1, 16'h7788, 1'b0, 256};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1};
    vecs[9] = '{1'b1, 16'h0A0B, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 16'h0A0B, 1'b0, 256};

    tick();
    tick();
    check("reset send", {31'd0, sccb_send}, 0);
    check("reset acks", {30'd0, a_ack, b_ack}, 0);
    check("reset reg_value", {16'd0, sccb_reg, sccb_value}, 0);
    check("reset grant_b", {31'd0, grant_b}, 0);
    check("reset busy", {31'd0, busy}, 1);
    check("reset err_timeout", {31'd0, err_timeout}, 0);
    rst_n = 1'b1;
    measure_gap("reset_release", 25000, 1'b0);
    $display("txn reset_release: settle done");

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Taken pulses outside ISSUE must be ignored.
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    check("idle_taken acks", {30'd0, a_ack, b_ack}, 0);
    check("idle_taken busy", {31'd0, busy}, 0);
    $display("txn idle_taken: ignored");

    b_req = 1'b1; b_cmd = 16'h0909;
    tick();
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    b_req = 1'b0;
    check("gap_taken first_ack", {30'd0, a_ack, b_ack}, 1);
    tick(); tick(); tick();
    sccb_taken = 1'b1;
    tick();
    sccb_taken = 1'b0;
    check("gap_taken acks", {30'd0, a_ack, b_ack}, 0);
    check("gap_taken busy", {31'd0, busy}, 1);
    measure_gap("gap_taken", 252, 1'b0);
    $display("txn gap_taken: ignored");

`ifdef SCCB_TIMEOUT_EN
    begin
      int n;
      a_req = 1'b1; a_cmd = 16'h4455;
      tick();
      n = 0;
      while (sccb_send && n < 200) begin
        n++;
        tick();
      end
      a_req = 1'b0;
      check("timeout send_cycles", n, 100);
      check("timeout err", {31'd0, err_timeout}, 1);
      check("timeout acks", {30'd0, a_ack, b_ack}, 2);
      measure_gap("timeout", 25000, 1'b1);
      check("timeout err_sticky", {31'd0, err_timeout}, 1);
      $display("txn timeout: send_cycles=%0d", n);
    end
`else
    check("err_timeout tied", {31'd0, err_timeout}, 0);
`endif

    // Asynchronous reset in the middle of ISSUE.
    a_req = 1'b1; a_cmd = 16'h0E0F;
    tick();
    check("async_rst pre_send", {31'd0, sccb_send}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst send", {31'd0, sccb_send}, 0);
    check("async_rst busy", {31'd0, busy}, 1);
    check("async_rst err", {31'd0, err_timeout}, 0);
    check("async_rst reg_value", {16'd0, sccb_reg, sccb_value}, 0);
    $display("txn async_rst: applied mid-issue");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_cmd_arbiter.md
Name: sccb_cmd_arbiter

Overview:
- Shares the single SCCB command sender (send/taken handshake, 8-bit reg + 8-bit value) between two requesters.
  - Port A: the power-up register-table sequencer.
  - Port B: the runtime tuning path (exposure, gain, mirror).
- Sequences each command: issue, hold until taken, then an enforced inter-command gap. After a COM7 soft reset (0x12 <= 0x80) it inserts a long settle time.
- Sits between the requesters and the sender, replacing the direct send = ~finished tie.

Parameters:
- GAP_CYCLES, 256, idle clocks after every accepted command; values below 1 are treated as 1.
- RESET_WAIT_CYCLES, 25000, settle clocks after the 16'h1280 command and after rst_n deassertion (1 ms at 25 MHz).
- FIXED_PRIO_A, 1: 1 = A always wins a tie; 0 = round-robin on ties.
- TIMEOUT_CYCLES, 65535, used only with SCCB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A holds high while a_cmd is valid
- a_cmd  in  16  {reg, value}
- a_ack  out  1  one-cycle pulse: A's command consumed
- b_req  in  1  requester B request
- b_cmd  in  16  {reg, value}
- b_ack  out  1  one-cycle pulse: B's command consumed
- sccb_send  out  1  request to the sender
- sccb_reg  out  8  latched register address
- sccb_value  out  8  latched register value
- sccb_taken  in  1  sender accepted the command (one-cycle pulse)
- grant_b  out  1  0 = A owns the sender, 1 = B owns it; valid outside IDLE
- busy  out  1  high in any state except IDLE
- err_timeout  out  1  sticky timeout flag; tied 0 without SCCB_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sccb_send=0, a_ack=b_ack=0, sccb_reg/value=0, grant_b=0, busy=1, err_timeout=0.
  - Internal: state=GAP, gap counter loaded with RESET_WAIT_CYCLES-1, last-grant=B.
  - Purpose: lets a sender frame that was in flight drain before any new issue.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise choose a winner:
    - Only one requester high: it wins.
    - Both high, FIXED_PRIO_A=1: A wins.
    - Both high, FIXED_PRIO_A=0: the port not granted last wins.
  - Latch the winner's cmd into sccb_reg/sccb_value and set grant_b in the same edge.
  - Winner cmd = 16'hFFFF (table end marker): pulse ack next cycle, no issue, go to GAP with 1 cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - sccb_send=1; reg/value held stable.
  - On sccb_taken: next edge drops send, pulses the winner's ack for exactly one cycle, goes to GAP.
  - Gap count: RESET_WAIT_CYCLES if the latched cmd = 16'h1280, else GAP_CYCLES.
  - sccb_taken outside ISSUE is ignored.
- GAP:
  - Counter decrements to 0, then go to IDLE.
  - Requesters are not sampled in GAP.
  - A requester must deassert req or present a new cmd in the cycle after its ack. The GAP of at least 1 cycle guarantees no double issue.
- Request changes: requests are never pre-empted once latched. A req dropping during ISSUE does not abort the command; the ack still fires.
- Counter width: $clog2(max of GAP_CYCLES, RESET_WAIT_CYCLES, TIMEOUT_CYCLES)+1. Arithmetic is unsigned, with no wrap (the counter stops at 0).
- Latency, IDLE with req high to sccb_send high: 1 cycle.
- Throughput: at most one command per (sender frame + GAP + 2) cycles.

Optional Feature:
- SCCB_TIMEOUT_EN defined:
  - ISSUE counts cycles. If TIMEOUT_CYCLES elapse with no sccb_taken: drop send, set sticky err_timeout, pulse the winner's ack (command discarded), enter GAP with RESET_WAIT_CYCLES.
  - err_timeout clears only on rst_n.
- Undefined:
  - ISSUE waits indefinitely; err_timeout is constant 0 and no timeout counter logic is generated.

Decomposition:
- Shared package:
  - State encoding: IDLE/ISSUE/GAP.
  - Constants: CMD_END=16'hFFFF, CMD_COM7_RESET=16'h1280, OV7670 SCCB id 8'h42.
- Sub-module sccb_gap_timer: loadable down-counter with zero flag, also reused for the timeout count.
- The arbitration/FSM stays flat in the top.

Test Plan:
- Reset release with no requests, default parameters: busy stays high 25000 cycles, then IDLE; no send.
- A requests 16'h3A04 alone: send high 1 cycle after sampling, reg=0x3A, value=0x04. Taken at cycle N gives a_ack at N+1, then 256 gap cycles before the next issue.
- A and B request together, FIXED_PRIO_A=0, last grant A: B is issued first (grant_b=1), then A after the gap.
- A issues 16'h1280: after taken, B's pending 16'h1300 is not issued for 25000 cycles.
- A presents 16'hFFFF: a_ack pulses, sccb_send never rises, B is serviced after the 1-cycle gap.
- SCCB_TIMEOUT_EN, TIMEOUT_CYCLES=100, taken never asserted:
  - send drops after 100 cycles, err_timeout=1, a_ack pulses.
  - rst_n mid-ISSUE forces send=0 asynchronously.
